stage_reg_read: RTL and testbench
=================================

Name: stage_reg_read

Overview:
- Operand-read stage of the pipeline.
- Owns the 16x32 register file; its write port is driven by the write-back stage.
- Reads two source operands for the instruction leaving decode, with write-through bypass from write-back.
- Tracks in-flight destination writes with a per-register pending-count scoreboard, stalls decode on RAW hazards, and presents a registered, handshaked bundle to execute.

Parameters:
- DBITS, 32, data/register width.
- REG_INDEX_BIT_WIDTH, 4, register index width (NREGS = 2**REG_INDEX_BIT_WIDTH).
- CNT_BITS, 2, pending-write counter width per register (max in flight = 2**CNT_BITS-1).
- CTRL_BITS, 16, opaque control bundle passed through to execute.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_valid  input  1  decode presents an instruction.
- id_ready  output  1  stage accepts it this cycle.
- id_src1, id_src2  input  REG_INDEX_BIT_WIDTH each  source register indices.
- id_use1, id_use2  input  1 each  source actually read (hazard-checked only if set).
- id_dest  input  REG_INDEX_BIT_WIDTH  destination index.
- id_wr_reg  input  1  instruction writes id_dest.
- id_ctrl  input  CTRL_BITS  passthrough control.
- wb_retire  input  1  one in-flight writer of wb_addr retires (written or squashed).
- wb_wr  input  1  write wb_din to wb_addr; legal only with wb_retire=1.
- wb_addr  input  REG_INDEX_BIT_WIDTH  write-back register index.
- wb_din  input  DBITS  write-back data.
- flush  input  1  squash the held output instruction and block acceptance this cycle.
- ex_valid  output  1  output bundle valid.
- ex_ready  input  1  execute consumes bundle.
- ex_op1, ex_op2  output  DBITS each  operand values.
- ex_dest  output  REG_INDEX_BIT_WIDTH  destination index.
- ex_wr_reg  output  1  destination-write flag.
- ex_ctrl  output  CTRL_BITS  control bundle.

Behaviour:
- Reset (reset=0, asynchronous): all registers, all counters and all outputs are 0.
- Register file:
  - Written on the clock edge when wb_wr=1.
  - Read combinationally.
  - Write-through: if wb_wr=1 and wb_addr==srcN, the operand is wb_din.
  - wb_wr=1 with wb_retire=0 is ignored: no write and no count change.
- Scoreboard, per register r:
  - cnt_next = cnt[r] + inc − dec_wb − dec_fl, where:
    - inc = 1 when an instruction with id_wr_reg=1 and id_dest==r is accepted.
    - dec_wb = 1 when wb_retire=1 and wb_addr==r.
    - dec_fl = 1 when flush=1, ex_valid=1, ex_wr_reg=1 and ex_dest==r.
  - All three terms may hit the same r in one cycle. No saturation wrap; counts never go below 0. Underflow is a protocol error, guarded by a bench assertion.
- Hazard for source N: id_useN=1 and (cnt[srcN] − dec_wb_for_srcN) != 0.
  - A write-back retiring the last pending writer in the same cycle resolves the hazard via bypass.
- Saturation: id_wr_reg=1 and cnt[id_dest] == 2**CNT_BITS−1.
- advance = !ex_valid || ex_ready.
- id_ready = advance && !flush && !hazard1 && !hazard2 && !saturation. It is combinational and does not depend on id_valid.
- Accept (id_valid && id_ready):
  - Next cycle ex_valid=1, with ex_op1/ex_op2 latched from bypassed reads and ex_dest/ex_wr_reg/ex_ctrl latched from id_*.
  - Latency is exactly 1 cycle.
- Output register:
  - No accept and advance → ex_valid clears to 0.
  - !advance → the whole bundle holds stable.
  - flush=1 → ex_valid clears to 0; data fields may hold.
- Unused sources: if id_useN=0, ex_opN is still the read value but is never hazard-checked.
- Self-dependence: with id_src==id_dest, the hazard check uses the pre-increment count. An instruction never stalls on itself.

Test Plan:
- Reset then write-back wr/retire r3=0xDEADBEEF; issue src1=r3, use1=1 → id_ready=1, ex_op1=0xDEADBEEF one cycle later, ex_valid=1.
- Issue writer dest=r5; next cycle issue reader src1=r5 → id_ready=0 while cnt[r5]=1. Then wb_retire/wb_wr r5=0x12345678 → id_ready=1 that cycle and ex_op1=0x12345678 via bypass.
- Hold ex_ready=0 with ex_valid=1 → id_ready=0 and bundle unchanged for 5 cycles. Raise ex_ready → next queued instruction appears after 1 cycle.
- Issue 3 writers to r7 (CNT_BITS=2) → 4th writer to r7 sees id_ready=0. A wb_retire on r7 in the same cycle does not unblock it; the 4th is accepted the following cycle.
- Issue writer dest=r2 and assert flush while it is in ex → ex_valid=0 next cycle, cnt[r2]=0, and a reader of r2 is not stalled. Flush coinciding with wb_retire r2 for an older writer drops cnt[r2] from 2 to 0.
- Assert reset mid-stall with ex_valid=1 and nonzero counters → ex_valid=0, all counts 0 and register reads return 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stage_reg_read.sv
`default_nettype none
// ============================================================================
//  Module   : stage_reg_read
//  Brief    : Operand-read stage. Holds the register file, bypasses write-back
//             data into source reads, keeps a pending-write scoreboard per
//             register and presents a registered bundle to execute.
//  Revision : 1.0
// ============================================================================
module stage_reg_read #(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int CNT_BITS            = 2,
    parameter int CTRL_BITS           = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           id_valid,
    output logic                           id_ready,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src2,
    input  logic                           id_use1,
    input  logic                           id_use2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_dest,
    input  logic                           id_wr_reg,
    input  logic [CTRL_BITS-1:0]           id_ctrl,
    input  logic                           wb_retire,
    input  logic                           wb_wr,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_addr,
    input  logic [DBITS-1:0]               wb_din,
    input  logic                           flush,
    output logic                           ex_valid,
    input  logic                           ex_ready,
    output logic [DBITS-1:0]               ex_op1,
    output logic [DBITS-1:0]               ex_op2,
    output logic [REG_INDEX_BIT_WIDTH-1:0] ex_dest,
    output logic                           ex_wr_reg,
    output logic [CTRL_BITS-1:0]           ex_ctrl
);

    localparam int                  NREGS     = 2**REG_INDEX_BIT_WIDTH;
    localparam logic [CNT_BITS-1:0] C_CNT_MAX = '1;

    logic [DBITS-1:0]    r_regs    [NREGS];
    logic [CNT_BITS-1:0] r_cnt     [NREGS];
    logic [CNT_BITS-1:0] w_cnt_nxt [NREGS];

    logic             w_wb_we;
    logic [DBITS-1:0] w_rd1;
    logic [DBITS-1:0] w_rd2;
    logic             w_dec1;
    logic             w_dec2;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_sat;
    logic             w_advance;
    logic             w_accept;

    // A write without a retire is not a legal write-back and is dropped.
    assign w_wb_we = wb_wr && wb_retire;

    assign w_rd1 = (w_wb_we && (wb_addr == id_src1)) ? wb_din : r_regs[id_src1];
    assign w_rd2 = (w_wb_we && (wb_addr == id_src2)) ? wb_din : r_regs[id_src2];

    // A retire in this cycle already removes its writer from the hazard count.
    assign w_dec1 = wb_retire && (wb_addr == id_src1);
    assign w_dec2 = wb_retire && (wb_addr == id_src2);
    assign w_haz1 = id_use1 && (r_cnt[id_src1] != CNT_BITS'(w_dec1));
    assign w_haz2 = id_use2 && (r_cnt[id_src2] != CNT_BITS'(w_dec2));
    assign w_sat  = id_wr_reg && (r_cnt[id_dest] == C_CNT_MAX);

    assign w_advance = !ex_valid || ex_ready;
    assign id_ready  = reset && w_advance && !flush && !w_haz1 && !w_haz2 && !w_sat;
    assign w_accept  = id_valid && id_ready;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_nxt[i] = r_cnt[i]
                + CNT_BITS'(w_accept && id_wr_reg && (id_dest == REG_INDEX_BIT_WIDTH'(i)))
                - CNT_BITS'(wb_retire && (wb_addr == REG_INDEX_BIT_WIDTH'(i)))
                - CNT_BITS'(flush && ex_valid && ex_wr_reg && (ex_dest == REG_INDEX_BIT_WIDTH'(i)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_wb_we) begin
                r_regs[wb_addr] <= wb_din;
            end
        end
    end

    // Flush only kills the valid bit; the data fields may keep stale values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid  <= 1'b0;
            ex_op1    <= '0;
            ex_op2    <= '0;
            ex_dest   <= '0;
            ex_wr_reg <= 1'b0;
            ex_ctrl   <= '0;
        end else begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (w_advance) begin
                ex_valid <= w_accept;
            end
            if (w_accept) begin
                ex_op1    <= w_rd1;
                ex_op2    <= w_rd2;
                ex_dest   <= id_dest;
                ex_wr_reg <= id_wr_reg;
                ex_ctrl   <= id_ctrl;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_reg_read.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_reg_read
//  Brief    : Directed self-checking bench for stage_reg_read.
//  Revision : 1.0
// ============================================================================
module tb_stage_reg_read;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_use1;
    logic        id_use2;
    logic [3:0]  id_dest;
    logic        id_wr_reg;
    logic [15:0] id_ctrl;
    logic        wb_retire;
    logic        wb_wr;
    logic [3:0]  wb_addr;
    logic [31:0] wb_din;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [3:0]  ex_dest;
    logic        ex_wr_reg;
    logic [15:0] ex_ctrl;

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt [16];

    stage_reg_read dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_src1   (id_src1),
        .id_src2   (id_src2),
        .id_use1   (id_use1),
        .id_use2   (id_use2),
        .id_dest   (id_dest),
        .id_wr_reg (id_wr_reg),
        .id_ctrl   (id_ctrl),
        .wb_retire (wb_retire),
        .wb_wr     (wb_wr),
        .wb_addr   (wb_addr),
        .wb_din    (wb_din),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op1    (ex_op1),
        .ex_op2    (ex_op2),
        .ex_dest   (ex_dest),
        .ex_wr_reg (ex_wr_reg),
        .ex_ctrl   (ex_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Protocol guard: the stimulus must never retire a writer that is not in flight.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                int nxt;
                nxt = m_cnt[r]
                    + ((id_valid && id_ready && id_wr_reg && id_dest == 4'(r)) ? 1 : 0)
                    - ((wb_retire && wb_addr == 4'(r)) ? 1 : 0)
                    - ((flush && ex_valid && ex_wr_reg && ex_dest == 4'(r)) ? 1 : 0);
                if (wb_retire && wb_addr == 4'(r)) chk("no_underflow", 64'(nxt >= 0), 64'd1);
                m_cnt[r] = (nxt < 0) ? 0 : nxt;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_use1 = 0; id_use2 = 0;
        id_dest = 0; id_wr_reg = 0; id_ctrl = 0;
        wb_retire = 0; wb_wr = 0; wb_addr = 0; wb_din = 0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic issue(input logic [3:0] s1, input logic u1, input logic [3:0] s2, input logic u2,
                         input logic [3:0] d, input logic w, input logic [15:0] c);
        id_valid = 1; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
        id_dest = d; id_wr_reg = w; id_ctrl = c;
    endtask

    task automatic wb(input logic wr, input logic [3:0] a, input logic [31:0] d);
        wb_retire = 1; wb_wr = wr; wb_addr = a; wb_din = d;
    endtask

    initial begin
        reset = 0;
        idle();
        #2;
        chk("rst_valid", ex_valid, 0);
        chk("rst_ready", id_ready, 0);
        chk("rst_op1",   ex_op1,   0);
        chk("rst_ctrl",  ex_ctrl,  0);
        @(posedge clk); #1;
        reset = 1;

        // Bypass of a retiring write into a same-cycle read
        idle(); issue(0, 0, 0, 0, 3, 1, 16'h1111);
        #1 chk("t1_ready", id_ready, 1);
        tick();
        chk("t1_valid", ex_valid, 1);
        chk("t1_dest",  ex_dest,  3);
        chk("t1_ctrl",  ex_ctrl,  16'h1111);
        idle(); issue(3, 1, 0, 1, 0, 0, 16'h2222); wb(1, 3, 32'hDEADBEEF);
        #1 chk("bypass_ready", id_ready, 1);
        tick();
        chk("bypass_op1",   ex_op1,    32'hDEADBEEF);
        chk("bypass_op2",   ex_op2,    0);
        chk("bypass_wrreg", ex_wr_reg, 0);
        chk("bypass_valid", ex_valid,  1);
        idle(); issue(0, 1, 3, 1, 4, 0, 16'h2323);
        #1 chk("rf_ready", id_ready, 1);
        tick();
        chk("rf_op2", ex_op2, 32'hDEADBEEF);

        // RAW hazard on r5 and release through bypass
        idle(); issue(3, 1, 0, 0, 5, 1, 16'h5555);
        #1 chk("w5_ready", id_ready, 1);
        tick();
        idle(); issue(5, 0, 0, 0, 1, 0, 16'h0505);
        #1 chk("unused_src_ready", id_ready, 1);
        id_use1 = 1;
        #1 chk("raw_stall", id_ready, 0);
        tick();
        chk("stall_bubble", ex_valid, 0);
        idle(); issue(5, 1, 0, 0, 1, 0, 16'h0505); wb(1, 5, 32'h12345678);
        #1 chk("raw_resolve", id_ready, 1);
        tick();
        chk("raw_op1",   ex_op1,   32'h12345678);
        chk("raw_valid", ex_valid, 1);

        // Backpressure holds the bundle
        idle(); ex_ready = 0; issue(0, 1, 0, 0, 8, 0, 16'h3333);
        #1 chk("bp_ready", id_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", ex_valid, 1);
            chk("bp_op1",   ex_op1,   32'h12345678);
            chk("bp_ctrl",  ex_ctrl,  16'h0505);
            chk("bp_hold_ready", id_ready, 0);
        end
        ex_ready = 1;
        #1 chk("bp_release", id_ready, 1);
        tick();
        chk("bp_next_ctrl", ex_ctrl, 16'h3333);
        chk("bp_next_dest", ex_dest, 8);

        // Saturation of r7
        for (int k = 0; k < 3; k++) begin
            idle(); issue(0, 0, 0, 0, 7, 1, 16'h0700 + 16'(k));
            #1 chk("sat_fill", id_ready, 1);
            tick();
        end
        idle(); issue(0, 0, 0, 0, 7, 1, 16'h0704);
        #1 chk("sat_block", id_ready, 0);
        wb(0, 7, 0);
        #1 chk("sat_wb_same", id_ready, 0);
        tick();
        chk("sat_bubble", ex_valid, 0);
        idle(); issue(0, 0, 0, 0, 7, 1, 16'h0704);
        #1 chk("sat_accept", id_ready, 1);
        tick();
        chk("sat_ctrl", ex_ctrl, 16'h0704);
        for (int k = 0; k < 3; k++) begin
            idle(); wb(0, 7, 0);
            tick();
        end

        // An instruction never stalls on its own destination
        idle(); issue(6, 1, 6, 1, 6, 1, 16'h0606);
        #1 chk("self_dep", id_ready, 1);
        tick();
        idle(); wb(1, 6, 32'hA5A5A5A5);
        tick();

        // Flush of a writer held in ex
        idle(); issue(0, 0, 0, 0, 2, 1, 16'h0202);
        tick();
        idle(); ex_ready = 0; flush = 1; issue(2, 1, 0, 0, 0, 0, 16'h2020);
        #1 chk("flush_block", id_ready, 0);
        tick();
        chk("flush_kill", ex_valid, 0);
        idle(); issue(2, 1, 0, 0, 0, 0, 16'h2020);
        #1 chk("flush_cnt_clear", id_ready, 1);
        tick();
        idle(); issue(0, 0, 0, 0, 2, 1, 16'h2001);
        tick();
        idle(); issue(0, 0, 0, 0, 2, 1, 16'h2002);
        tick();
        idle(); ex_ready = 0; flush = 1; wb(1, 2, 32'h0BADF00D);
        #1 chk("flush_wb_block", id_ready, 0);
        tick();
        chk("flush_wb_kill", ex_valid, 0);
        idle(); issue(2, 1, 2, 1, 0, 0, 16'h2222);
        #1 chk("flush_wb_cnt0", id_ready, 1);
        tick();
        chk("flush_wb_op1", ex_op1, 32'h0BADF00D);

        // Asynchronous reset in the middle of a stall
        idle(); issue(3, 0, 0, 0, 9, 1, 16'h0909);
        tick();
        idle(); ex_ready = 0; issue(9, 1, 0, 0, 0, 0, 16'h9999);
        #1 chk("pre_rst_stall", id_ready, 0);
        chk("pre_rst_valid", ex_valid, 1);
        chk("pre_rst_op1",   ex_op1,   32'hDEADBEEF);
        #1 reset = 0;
        #1 chk("arst_valid", ex_valid, 0);
        chk("arst_op1",   ex_op1,  0);
        chk("arst_dest",  ex_dest, 0);
        chk("arst_ctrl",  ex_ctrl, 0);
        chk("arst_ready", id_ready, 0);
        #1 reset = 1;
        idle(); issue(3, 1, 9, 1, 0, 0, 16'h3939);
        #1 chk("arst_cnt_clear", id_ready, 1);
        tick();
        chk("arst_rf_op1", ex_op1,   0);
        chk("arst_rf_op2", ex_op2,   0);
        chk("arst_valid2", ex_valid, 1);

        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
